vga_timing_generator: RTL and testbench

- Pixel-scan source for the whole drawing pipeline.
- Generates the scan coordinate bus and the once-per-frame `startOfFrame` strobe consumed by every object block (ground, trees, player).
- Accepts the final composited 8-bit RGB back from the priority mux and drives the VGA pins.
- Holds sync and blanking delayed by the object pipeline latency, so pins see pixel (X,Y) in step with its RGB.

---
 rtl/vga_timing_generator_pkg.sv | 34 +++
 rtl/vga_timing_generator_pipe_delay.sv | 36 +++
 rtl/vga_timing_generator.sv | 128 ++++++++++++
 tb/tb_vga_timing_generator.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_generator_pkg.sv
// Shared types and default 640x480@60 timing for the VGA scan pipeline.
// Latency: n/a (types only). Backpressure: n/a.
// Consumers: the timing generator and every object block reading drawCoordinates.
package vga_pkg;

    localparam int VGA_H_ACTIVE     = 640;
    localparam int VGA_H_FP         = 16;
    localparam int VGA_H_SYNC       = 96;
    localparam int VGA_H_BP         = 48;
    localparam int VGA_V_ACTIVE     = 480;
    localparam int VGA_V_FP         = 10;
    localparam int VGA_V_SYNC       = 2;
    localparam int VGA_V_BP         = 33;
    localparam int VGA_PIPE_LATENCY = 2;

    typedef logic [1:0][10:0] coord_t;

    typedef enum logic {
        AXIS_X = 1'b0,
        AXIS_Y = 1'b1
    } coord_axis_e;

    typedef struct packed {
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
    } rgb332_t;

    // Replicating the MSB keeps full-scale 3-bit values at full-scale 4-bit.
    function automatic logic [3:0] expand3(input logic [2:0] c);
        return {c, c[2]};
    endfunction

endpackage

// File: rtl/vga_timing_generator_pipe_delay.sv
// Fixed-depth shift register; DEPTH=0 degenerates to a wire.
// Latency: DEPTH clocks. Backpressure: none, shifts every clock.
// All stages reset to RESET_VAL so the output is idle while refilling.
module pipe_delay #(
    parameter int               WIDTH     = 3,
    parameter int               DEPTH     = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic [WIDTH-1:0] i_dat,
    output logic [WIDTH-1:0] o_dat
);

    generate
        if (DEPTH == 0) begin : g_wire
            assign o_dat = i_dat;
        end else begin : g_shift
            logic [DEPTH-1:0][WIDTH-1:0] r_stage;

            always_ff @(posedge clk or negedge resetN) begin
                if (!resetN) begin
                    r_stage <= {DEPTH{RESET_VAL}};
                end else begin
                    r_stage[0] <= i_dat;
                    for (int i = 1; i < DEPTH; i++) begin
                        r_stage[i] <= r_stage[i-1];
                    end
                end
            end

            assign o_dat = r_stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_generator.sv
// VGA scan counters, start-of-frame strobe, and sync/blank aligned to returning RGB.
// Latency: pins lag drawCoordinates by PIPE_LATENCY+1 clocks. Backpressure: none.
// Free-running: one counter step per clock, no stall input.
module vga_timing_generator
    import vga_pkg::*;
#(
    parameter int H_ACTIVE     = VGA_H_ACTIVE,
    parameter int H_FP         = VGA_H_FP,
    parameter int H_SYNC       = VGA_H_SYNC,
    parameter int H_BP         = VGA_H_BP,
    parameter int V_ACTIVE     = VGA_V_ACTIVE,
    parameter int V_FP         = VGA_V_FP,
    parameter int V_SYNC       = VGA_V_SYNC,
    parameter int V_BP         = VGA_V_BP,
    parameter int PIPE_LATENCY = VGA_PIPE_LATENCY
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic [7:0] RGBIn,
    output coord_t     drawCoordinates,
    output logic       startOfFrame,
    output logic       hsyncN,
    output logic       vsyncN,
    output logic       blankN,
    output logic [3:0] red,
    output logic [3:0] green,
    output logic [3:0] blue
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] C_H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] C_V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] C_H_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0] C_V_ACT    = 11'(V_ACTIVE);
    localparam logic [10:0] C_HS_START = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] C_HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] C_VS_START = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] C_VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic [10:0] r_h_cnt;
    logic [10:0] r_v_cnt;
    logic        r_sof;
    logic [10:0] w_h_next;
    logic [10:0] w_v_next;

    always_comb begin
        w_h_next = r_h_cnt + 11'd1;
        w_v_next = r_v_cnt;
        if (r_h_cnt == C_H_LAST) begin
            w_h_next = '0;
            w_v_next = (r_v_cnt == C_V_LAST) ? '0 : r_v_cnt + 11'd1;
        end
    end

    // The strobe is decoded from the next count so it lines up with (0, V_ACTIVE).
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
            r_sof   <= 1'b0;
        end else begin
            r_h_cnt <= w_h_next;
            r_v_cnt <= w_v_next;
            r_sof   <= (w_h_next == '0) && (w_v_next == C_V_ACT);
        end
    end

    assign drawCoordinates[AXIS_X] = r_h_cnt;
    assign drawCoordinates[AXIS_Y] = r_v_cnt;
    assign startOfFrame            = r_sof;

    logic [2:0] w_raw;
    logic [2:0] w_dly;

    assign w_raw[2] = (r_h_cnt < C_H_ACT) && (r_v_cnt < C_V_ACT);
    assign w_raw[1] = !((r_h_cnt >= C_HS_START) && (r_h_cnt < C_HS_END));
    assign w_raw[0] = !((r_v_cnt >= C_VS_START) && (r_v_cnt < C_VS_END));

    pipe_delay #(
        .WIDTH     (3),
        .DEPTH     (PIPE_LATENCY),
        .RESET_VAL (3'b011)
    ) u_pipe_delay (
        .clk    (clk),
        .resetN (resetN),
        .i_dat  (w_raw),
        .o_dat  (w_dly)
    );

    rgb332_t    w_rgb;
    logic       r_blank;
    logic       r_hs;
    logic       r_vs;
    logic [3:0] r_red;
    logic [3:0] r_green;
    logic [3:0] r_blue;

    assign w_rgb = rgb332_t'(RGBIn);

    // RGBIn for pixel N arrives together with the delayed flags for pixel N.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_blank <= 1'b0;
            r_hs    <= 1'b1;
            r_vs    <= 1'b1;
            r_red   <= '0;
            r_green <= '0;
            r_blue  <= '0;
        end else begin
            r_blank <= w_dly[2];
            r_hs    <= w_dly[1];
            r_vs    <= w_dly[0];
            r_red   <= w_dly[2] ? expand3(w_rgb.r) : 4'h0;
            r_green <= w_dly[2] ? expand3(w_rgb.g) : 4'h0;
            r_blue  <= w_dly[2] ? {w_rgb.b, w_rgb.b} : 4'h0;
        end
    end

    assign blankN = r_blank;
    assign hsyncN = r_hs;
    assign vsyncN = r_vs;
    assign red    = r_red;
    assign green  = r_green;
    assign blue   = r_blue;

endmodule

// File: tb/tb_vga_timing_generator.sv
// Scoreboard bench: a reference scan model pushes expected flags per pixel, popped when pins update.
// Full horizontal timing, shortened vertical timing; DUTs at PIPE_LATENCY 2 and 0 side by side.
module tb_vga_timing_generator;
    import vga_pkg::*;

    localparam int H_ACT = 640, H_FP = 16, H_SYNC = 96, H_BP = 48, H_TOT = 800;
    localparam int V_ACT = 6, V_FP = 2, V_SYNC = 2, V_BP = 2, V_TOT = 12;
    localparam logic [14:0] PINS_RST = 15'h3000;

    logic clk = 1'b0;
    always #20 clk = ~clk;

    logic       resetN;
    logic [7:0] RGBIn;
    coord_t     dc2, dc0;
    logic       sof2, sof0, hs2, hs0, vs2, vs0, bl2, bl0;
    logic [3:0] r2, g2, b2, r0, g0, b0;
    logic [14:0] pins2, pins0;

    assign pins2 = {bl2, hs2, vs2, r2, g2, b2};
    assign pins0 = {bl0, hs0, vs0, r0, g0, b0};

    vga_timing_generator #(
        .H_ACTIVE(H_ACT), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACT), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP), .PIPE_LATENCY(2)
    ) dut2 (
        .clk(clk), .resetN(resetN), .RGBIn(RGBIn), .drawCoordinates(dc2), .startOfFrame(sof2),
        .hsyncN(hs2), .vsyncN(vs2), .blankN(bl2), .red(r2), .green(g2), .blue(b2)
    );

    vga_timing_generator #(
        .H_ACTIVE(H_ACT), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACT), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP), .PIPE_LATENCY(0)
    ) dut0 (
        .clk(clk), .resetN(resetN), .RGBIn(RGBIn), .drawCoordinates(dc0), .startOfFrame(sof0),
        .hsyncN(hs0), .vsyncN(vs0), .blankN(bl0), .red(r0), .green(g0), .blue(b0)
    );

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic [2:0]  f;
    } sb_t;

    sb_t         q2[$];
    sb_t         q0[$];
    sb_t         cur2, cur0;
    int          checks = 0;
    int          errors = 0;
    int          t = 0;
    int          mh = 0;
    int          mv = 0;
    logic [14:0] exp2, exp0;
    logic        exp_sof;

    function automatic logic [2:0] raw(input int x, input int y);
        return {(x < H_ACT) && (y < V_ACT),
                !((x >= H_ACT + H_FP) && (x < H_ACT + H_FP + H_SYNC)),
                !((y >= V_ACT + V_FP) && (y < V_ACT + V_FP + V_SYNC))};
    endfunction

    function automatic logic [11:0] colour(input logic act, input logic [7:0] c);
        if (!act) return 12'h000;
        return {c[7:5], c[7], c[4:2], c[4], c[1:0], c[1:0]};
    endfunction

    task automatic clear_model();
        mh = 0; mv = 0; t = 0;
        q2.delete(); q0.delete();
        exp2 = PINS_RST; exp0 = PINS_RST; exp_sof = 1'b0;
    endtask

    // Called at a falling edge; returns at the next falling edge with expectations updated.
    task automatic step();
        sb_t        e;
        logic [7:0] c;
        e.x = 11'(mh); e.y = 11'(mv); e.f = raw(mh, mv);
        q2.push_back(e);
        q0.push_back(e);
        c = RGBIn;
        @(posedge clk);
        t++;
        if (mh == H_TOT - 1) begin
            mh = 0;
            mv = (mv == V_TOT - 1) ? 0 : mv + 1;
        end else begin
            mh++;
        end
        exp_sof = (mh == 0) && (mv == V_ACT);
        if (q2.size() > 2) begin
            cur2 = q2.pop_front();
            exp2 = {cur2.f, colour(cur2.f[2], c)};
        end else begin
            cur2 = '{x: 11'h7FF, y: 11'h7FF, f: 3'b011};
            exp2 = PINS_RST;
        end
        cur0 = q0.pop_front();
        exp0 = {cur0.f, colour(cur0.f[2], c)};
        @(negedge clk);
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        RGBIn  = 8'hFF;
        clear_model();
        repeat (10) begin
            @(negedge clk);
            checks++;
            if ({pins2, pins0, sof2, sof0, dc2, dc0} !== {PINS_RST, PINS_RST, 2'b00, 44'd0}) begin
                errors++;
                $display("FAIL reset_hold got pins %h/%h sof %b%b dc %h/%h required pins %h sof 0 dc 0",
                         pins2, pins0, sof2, sof0, dc2, dc0, PINS_RST);
            end
        end
        resetN = 1'b1;
        checks++;
        if (dc2 !== 22'd0 || dc0 !== 22'd0) begin
            errors++;
            $display("FAIL release_coord got %h/%h required 0", dc2, dc0);
        end
        for (int i = 1; i <= 2; i++) begin
            step();
            checks++;
            if (dc2 !== {11'd0, 11'(i)} || dc0 !== {11'd0, 11'(i)}) begin
                errors++;
                $display("FAIL x_increment step %0d got %h/%h required x=%0d y=0", i, dc2, dc0, i);
            end
        end
    endtask

    task automatic test_line();
        int hs_first = -1, hs0_first = -1, hs_cnt = 0, bl_first = -1, bl_last = -1;
        while (t < H_TOT) begin
            step();
            checks++;
            if (pins2 !== exp2 || pins0 !== exp0 || dc2 !== {11'(mv), 11'(mh)} || dc0 !== {11'(mv), 11'(mh)}) begin
                errors++;
                $display("FAIL line t=%0d got pins %h/%h dc %h/%h required pins %h/%h x=%0d y=%0d",
                         t, pins2, pins0, dc2, dc0, exp2, exp0, mh, mv);
            end
            if (hs2 === 1'b0) begin
                if (hs_first < 0) hs_first = t;
                hs_cnt++;
            end
            if (hs0 === 1'b0 && hs0_first < 0) hs0_first = t;
            if (bl2 === 1'b1) begin
                if (bl_first < 0) bl_first = t;
                bl_last = t;
            end
        end
        checks++;
        if (hs_first != 659 || hs_cnt != 96 || hs0_first != 657) begin
            errors++;
            $display("FAIL hsync_window got first %0d len %0d lat0 first %0d required 659 96 657",
                     hs_first, hs_cnt, hs0_first);
        end
        checks++;
        if (bl_first != 3 || bl_last != 642) begin
            errors++;
            $display("FAIL blank_window got %0d..%0d required 3..642", bl_first, bl_last);
        end
    endtask

    task automatic test_frame();
        int n_sof = 0, sof_a = -1, sof_b = -1, vs_low = 0;
        while (n_sof < 2 && t < 3 * H_TOT * V_TOT) begin
            step();
            checks++;
            if (sof2 !== exp_sof || sof0 !== exp_sof || pins2 !== exp2 || pins0 !== exp0) begin
                errors++;
                $display("FAIL frame t=%0d got sof %b%b pins %h/%h required sof %b pins %h/%h",
                         t, sof2, sof0, pins2, pins0, exp_sof, exp2, exp0);
            end
            if (n_sof == 1 && vs2 === 1'b0) vs_low++;
            if (sof2 === 1'b1) begin
                if (n_sof == 0) sof_a = t; else sof_b = t;
                n_sof++;
            end
        end
        checks++;
        if (n_sof != 2 || sof_a != H_TOT * V_ACT || sof_b - sof_a != H_TOT * V_TOT) begin
            errors++;
            $display("FAIL sof_timing got count %0d at %0d,%0d required 2 at %0d period %0d",
                     n_sof, sof_a, sof_b, H_TOT * V_ACT, H_TOT * V_TOT);
        end
        checks++;
        if (vs_low != H_TOT * V_SYNC) begin
            errors++;
            $display("FAIL vsync_len got %0d required %0d", vs_low, H_TOT * V_SYNC);
        end
    endtask

    task automatic test_colour();
        for (int i = 0; i < H_TOT * V_TOT; i++) begin
            if (mv == 0)            RGBIn = 8'hE0;
            else if (mv == 2)       RGBIn = 8'h1F;
            else if (mv == 1 || mv >= V_ACT) RGBIn = 8'hFF;
            else                    RGBIn = 8'($urandom);
            step();
            checks++;
            if (pins2 !== exp2 || pins0 !== exp0) begin
                errors++;
                $display("FAIL colour t=%0d got pins %h/%h required %h/%h", t, pins2, pins0, exp2, exp0);
            end
            if ((cur2.x == 11'd5 && cur2.y == 11'd0) || (cur2.x == 11'd100 && cur2.y == 11'd2) ||
                (cur2.x == 11'd100 && cur2.y == 11'd1) || (cur2.x == 11'd700 && cur2.y == 11'd1) ||
                (cur2.x == 11'd100 && cur2.y == 11'(V_ACT + 1))) begin
                logic [11:0] want;
                want = (cur2.y == 11'd0) ? 12'hF00 : (cur2.y == 11'd2) ? 12'h0FF :
                       (cur2.x == 11'd100 && cur2.y == 11'd1) ? 12'hFFF : 12'h000;
                checks++;
                if ({r2, g2, b2} !== want) begin
                    errors++;
                    $display("FAIL pixel (%0d,%0d) got rgb %h required %h", cur2.x, cur2.y, {r2, g2, b2}, want);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int guard = 0;
        RGBIn = 8'hFF;
        while (!(mh == 320 && mv == 3) && guard < 2 * H_TOT * V_TOT) begin
            step();
            guard++;
        end
        checks++;
        if (bl2 !== 1'b1 || r2 !== 4'hF) begin
            errors++;
            $display("FAIL pre_reset_active got blank %b red %h required 1 F", bl2, r2);
        end
        resetN = 1'b0;
        #1;
        checks++;
        if ({pins2, pins0, sof2, sof0, dc2, dc0} !== {PINS_RST, PINS_RST, 2'b00, 44'd0}) begin
            errors++;
            $display("FAIL async_reset got pins %h/%h dc %h/%h required pins %h dc 0", pins2, pins0, dc2, dc0, PINS_RST);
        end
        repeat (3) @(negedge clk);
        resetN = 1'b1;
        clear_model();
        for (int i = 0; i < 1000; i++) begin
            step();
            checks++;
            if (pins2 !== exp2 || pins0 !== exp0 || dc2 !== {11'(mv), 11'(mh)} || dc0 !== {11'(mv), 11'(mh)}) begin
                errors++;
                $display("FAIL restart t=%0d got pins %h/%h dc %h/%h required pins %h/%h x=%0d y=%0d",
                         t, pins2, pins0, dc2, dc0, exp2, exp0, mh, mv);
            end
        end
    endtask

    initial begin
        resetN = 1'b0;
        RGBIn  = 8'h00;
        test_reset();
        test_line();
        test_frame();
        test_colour();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
